// File: rtl/keccak_rc_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : keccak_rc_pkg                                              |
// | Description : Shared constants, state encoding and helper functions for  |
// |               the on-the-fly Keccak round-constant generator.            |
// |               Contents: LFSR seed and feedback taps, nr_max() for the    |
// |               largest round count at a given lane width, the FSM state   |
// |               enum, and is_rc_slice() mapping a slice to its rc bit.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package keccak_rc_pkg;

  // Seed of the 8-bit rc LFSR; rc(0) = 1.
  localparam logic [7:0] LFSR_INIT = 8'h01;

  // Feedback taps r6, r5, r4, r0 (x^8 + x^6 + x^5 + x^4 + 1).
  localparam logic [7:0] LFSR_TAPS = 8'b0111_0001;

  // Rounds in a full Keccak-f for lane width 2^l.
  function automatic logic [4:0] nr_max(input int l);
    return 5'(12 + 2 * l);
  endfunction

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SKIP   = 3'd1,
    FILL   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_e;

  // One-hot select of the rc bit carried by slice idx: bit j is set when
  // idx == 2^j - 1. Slices that carry no constant bit return zero.
  function automatic logic [6:0] is_rc_slice(input logic [6:0] idx);
    logic [6:0] hot;
    for (int j = 0; j < 7; j++) begin
      hot[j] = (idx == 7'((1 << j) - 1));
    end
    return hot;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_rc_lfsr_gen_lfsr.sv
// +--------------------------------------------------------------------------+
// | Module      : keccak_rc_lfsr                                             |
// | Description : 8-bit Keccak rc LFSR. Shifts right; the new MSB is the     |
// |               XOR of the tapped bits; output rc bit is r[0].             |
// | Ports       : clk          - clock                                       |
// |               rst_n        - asynchronous active-low reset               |
// |               i_load_init  - reload the seed (wins over i_step_en)       |
// |               i_step_en    - advance one step                            |
// |               o_rc_bit     - current rc output bit r[0]                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module keccak_rc_lfsr
  import keccak_rc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_load_init,
  input  logic i_step_en,
  output logic o_rc_bit
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_load_init) begin
      lfsr_d = LFSR_INIT;
    end else if (i_step_en) begin
      lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign o_rc_bit = lfsr_q[0];

endmodule

`default_nettype wire

// File: rtl/keccak_rc_lfsr_gen.sv
// +--------------------------------------------------------------------------+
// | Module      : keccak_rc_lfsr_gen                                         |
// | Description : Generates Keccak-p[25*W, nr] round constants from the rc   |
// |               LFSR and streams them SLICES_PARALLEL slices per beat over |
// |               a valid/ready handshake.                                   |
// | Ports       : ClkxCI/RstxRBI  clock, async active-low reset              |
// |               StartxSI, NumRoundsxDI, AbortxSI   control                 |
// |               RCxDO, RCValidxSO, RCReadyxSI      constant stream         |
// |               SliceNrxDO, RoundNrxDO             beat position           |
// |               BusyxSO, DonexSO                   status                  |
// | Options     : KECCAK_RC_PREFETCH_EN - fill the next round's bits in a    |
// |               shadow register while streaming to remove the bubble.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module keccak_rc_lfsr_gen
  import keccak_rc_pkg::*;
#(
  parameter int W                = 64,
  parameter int SLICES_PARALLEL  = 1,
  parameter int COUNTER_BITWIDTH = 6
) (
  input  logic                        ClkxCI,
  input  logic                        RstxRBI,
  input  logic                        StartxSI,
  input  logic [4:0]                  NumRoundsxDI,
  input  logic                        AbortxSI,
  output logic [SLICES_PARALLEL-1:0]  RCxDO,
  output logic                        RCValidxSO,
  input  logic                        RCReadyxSI,
  output logic [COUNTER_BITWIDTH-1:0] SliceNrxDO,
  output logic [4:0]                  RoundNrxDO,
  output logic                        BusyxSO,
  output logic                        DonexSO
);

  localparam int L = $clog2(W);
  localparam logic [4:0] NR_MAX = nr_max(L);
  localparam logic [COUNTER_BITWIDTH-1:0] LAST_SLICE =
    COUNTER_BITWIDTH'(W / SLICES_PARALLEL - 1);

  state_e                      state_q, state_d;
  logic [4:0]                  round_q, round_d;
  logic [COUNTER_BITWIDTH-1:0] slice_q, slice_d;
  logic [7:0]                  skip_q, skip_d;
  logic [2:0]                  step_q, step_d;
  logic [6:0]                  rc_bits_q, rc_bits_d;
  logic [4:0]                  nr_eff, round_start;
  logic                        lfsr_load, lfsr_step, lfsr_bit;
  logic                        valid, beat, last_slice, last_round;

`ifdef KECCAK_RC_PREFETCH_EN
  logic [6:0] shadow_q, shadow_d;
  logic [2:0] pf_cnt_q, pf_cnt_d;
  logic       pf_stall_q, pf_stall_d;
  logic       shadow_full;

  assign valid = (state_q == STREAM) && !pf_stall_q;
`else
  assign valid = (state_q == STREAM);
`endif

  assign beat       = valid && RCReadyxSI;
  assign last_slice = (slice_q == LAST_SLICE);
  assign last_round = (round_q == NR_MAX - 5'd1);

  keccak_rc_lfsr u_lfsr (
    .clk         (ClkxCI),
    .rst_n       (RstxRBI),
    .i_load_init (lfsr_load),
    .i_step_en   (lfsr_step),
    .o_rc_bit    (lfsr_bit)
  );

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    slice_d   = slice_q;
    skip_d    = skip_q;
    step_d    = step_q;
    rc_bits_d = rc_bits_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
`ifdef KECCAK_RC_PREFETCH_EN
    shadow_d    = shadow_q;
    pf_cnt_d    = pf_cnt_q;
    pf_stall_d  = pf_stall_q;
    shadow_full = 1'b0;
`endif
    // Out-of-range round counts fall back to the full permutation.
    nr_eff      = (NumRoundsxDI == 5'd0 || NumRoundsxDI > NR_MAX) ? NR_MAX : NumRoundsxDI;
    round_start = NR_MAX - nr_eff;

    case (state_q)
      IDLE: begin
        if (StartxSI) begin
          lfsr_load = 1'b1;
          round_d   = round_start;
          slice_d   = '0;
          step_d    = 3'd0;
          // Skipped rounds still consume 7 LFSR steps each.
          skip_d    = {3'b000, round_start} * 8'd7;
          state_d   = (round_start != 5'd0) ? SKIP : FILL;
`ifdef KECCAK_RC_PREFETCH_EN
          pf_cnt_d   = 3'd0;
          pf_stall_d = 1'b0;
`endif
        end
      end

      SKIP: begin
        lfsr_step = 1'b1;
        if (skip_q == 8'd1) begin
          state_d = FILL;
        end else begin
          skip_d = skip_q - 8'd1;
        end
      end

      FILL: begin
        lfsr_step          = 1'b1;
        rc_bits_d[step_q]  = lfsr_bit;
        if (step_q == 3'd6) begin
          step_d  = 3'd0;
          slice_d = '0;
          state_d = STREAM;
        end else begin
          step_d = step_q + 3'd1;
        end
      end

      STREAM: begin
`ifdef KECCAK_RC_PREFETCH_EN
        // Shadow capture runs every STREAM cycle, stalled or not, so the
        // next round's bits are ready as early as possible.
        if (pf_cnt_q != 3'd7) begin
          lfsr_step          = 1'b1;
          shadow_d[pf_cnt_q] = lfsr_bit;
          pf_cnt_d           = pf_cnt_q + 3'd1;
        end
        // Count 6 means the final shadow bit is being captured this cycle.
        shadow_full = (pf_cnt_q >= 3'd6);
        if (pf_stall_q) begin
          if (shadow_full) begin
            rc_bits_d  = shadow_d;
            pf_cnt_d   = 3'd0;
            pf_stall_d = 1'b0;
          end
        end else if (beat) begin
          if (last_slice) begin
            if (last_round) begin
              state_d = DONE;
            end else begin
              round_d = round_q + 5'd1;
              slice_d = '0;
              if (shadow_full) begin
                rc_bits_d = shadow_d;
                pf_cnt_d  = 3'd0;
              end else begin
                pf_stall_d = 1'b1;
              end
            end
          end else begin
            slice_d = slice_q + COUNTER_BITWIDTH'(1);
          end
        end
`else
        if (beat) begin
          if (last_slice) begin
            if (last_round) begin
              state_d = DONE;
            end else begin
              round_d = round_q + 5'd1;
              slice_d = '0;
              state_d = FILL;
            end
          end else begin
            slice_d = slice_q + COUNTER_BITWIDTH'(1);
          end
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition, including the final beat.
    if (AbortxSI) begin
      state_d   = IDLE;
      round_d   = 5'd0;
      slice_d   = '0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
`ifdef KECCAK_RC_PREFETCH_EN
      pf_stall_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxRBI) begin
    if (!RstxRBI) begin
      state_q    <= IDLE;
      round_q    <= 5'd0;
      slice_q    <= '0;
      skip_q     <= 8'd0;
      step_q     <= 3'd0;
      rc_bits_q  <= 7'd0;
`ifdef KECCAK_RC_PREFETCH_EN
      shadow_q   <= 7'd0;
      pf_cnt_q   <= 3'd0;
      pf_stall_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      slice_q    <= slice_d;
      skip_q     <= skip_d;
      step_q     <= step_d;
      rc_bits_q  <= rc_bits_d;
`ifdef KECCAK_RC_PREFETCH_EN
      shadow_q   <= shadow_d;
      pf_cnt_q   <= pf_cnt_d;
      pf_stall_q <= pf_stall_d;
`endif
    end
  end

  // Bit k of a beat is slice SliceNr*SP + k; only slices 2^j-1 carry a bit.
  for (genvar k = 0; k < SLICES_PARALLEL; k++) begin : g_rc_bit
    logic [6:0] idx;
    assign idx      = 7'(slice_q) * 7'(SLICES_PARALLEL) + 7'(k);
    assign RCxDO[k] = valid && (|(is_rc_slice(idx) & rc_bits_q));
  end

  assign RCValidxSO = valid;
  assign SliceNrxDO = slice_q;
  assign RoundNrxDO = round_q;
  assign BusyxSO    = (state_q != IDLE);
  assign DonexSO    = (state_q == DONE);

endmodule

`default_nettype wire
